dut_for_mer_measurement: RTL and testbench
==========================================

# dut_for_mer_measurement

Symbol-rate channel model used by the MER measurement chain. It takes mapped 4-ASK symbols, adds deterministic intersymbol interference (ISI) of programmable strength, and outputs three values:
- the impaired decision variable;
- the ideal (errorless) decision variable;
- their difference.

It sits between the LFSR/mapper symbol source and the slicer, averaging and error-accumulation blocks. One instance is used per I and Q rail.

## Interface
Parameters: none.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low; low clears all state immediately.
- clk_en  input  1  symbol-rate enable, one clk cycle high per symbol.
- in_data  input  18  signed 1s17 mapped symbol.
- isi_power  input  18  signed 1s17 ISI gain. Used with non-negative values in practice; any signed value must be handled correctly.
- decision_variable  output  18  signed 1s17 impaired symbol (main cursor + ISI), saturated.
- errorless_decision_variable  output  18  signed 1s17 main cursor, time-aligned with decision_variable.
- error  output  18  signed 1s17, equals decision_variable − errorless_decision_variable, saturated.

## Operation
Symbol delay line, three 18-bit registers x0 (newest), x1 (main cursor) and x2 (oldest). On each clk edge with clk_en=1:
- x0 <= in_data
- x1 <= x0
- x2 <= x1

ISI term, computed combinationally from the register values before the edge:
- s = x0 + x2, 19-bit signed, no overflow possible.
- p = s × isi_power, full-precision signed product (37 bits).
- isi = p >>> 17, arithmetic shift, i.e. floor toward −∞, no rounding.
- isi is kept wide, at least 20 bits.

Output registers, on the same clk_en edge:
- decision_variable <= sat18(x1 + isi)
- errorless_decision_variable <= x1
- error <= sat18(sat18(x1 + isi) − x1)

sat18 clamps to the range [−131072, +131071].

Control:
- clk_en=0: every register holds its value.
- reset low: all six registers go to 0 asynchronously.
- Outputs are purely registered; there is no combinational path from any input to any output.

## Timing
- Reset values: decision_variable = 0, errorless_decision_variable = 0, error = 0, x0 = x1 = x2 = 0.
- Latency: in_data sampled at clk_en edge k appears as errorless_decision_variable after clk_en edge k+2. decision_variable and error are updated on the same edge.
- Outputs change only on clk edges where clk_en=1 (or on asynchronous reset) and stay stable for the whole symbol period.
- isi_power is sampled only at clk_en edges. A change takes effect on the next enabled edge with no extra delay.
- Reset deasserted mid-stream: the pipeline restarts from zeros. The first two enabled edges output ISI computed with zero neighbours.
- Reset asserted while clk_en=1: reset wins.
- Back-to-back clk_en (held high every cycle) is legal; the block then operates at the clk rate.

## Test plan
- isi_power=0, random symbols from {±32768, ±98304} -> decision_variable == errorless_decision_variable and error == 0 on every symbol. errorless_decision_variable equals in_data delayed by 2 enables.
- isi_power=9268, in_data held at 32768 for more than 3 enables -> isi = 4634, decision_variable = 37402, errorless_decision_variable = 32768, error = 4634.
- isi_power=9268, in_data held at −32768 -> decision_variable = −37402, error = −4634.
- Saturation: in_data=131071 held, isi_power=131071 -> isi = 262140, decision_variable = 131071, error = 0. Mirror case: in_data=−131072, isi_power=131071 -> decision_variable = −131072.
- Floor rounding: isi_power=1, single symbol x0=+1 with zero neighbours -> isi = 0. With x0=−1 -> isi = −1, so error = −1 on the corresponding output.
- Control checks:
  - clk_en held low for 10 cycles while in_data changes -> all outputs unchanged.
  - reset pulsed low mid-stream, including during a clk_en cycle -> all outputs are 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/dut_for_mer_measurement.sv
// ============================================================================
// Module   : dut_for_mer_measurement
// Purpose  : Symbol-rate 4-ASK channel model with programmable symmetric ISI.
//            Outputs impaired, ideal and error decision variables (1s17).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dut_for_mer_measurement (
   input  logic               clk,
   input  logic               reset,
   input  logic               clk_en,
   input  logic signed [17:0] in_data,
   input  logic signed [17:0] isi_power,
   output logic signed [17:0] decision_variable,
   output logic signed [17:0] errorless_decision_variable,
   output logic signed [17:0] error
);

   localparam logic signed [20:0] C_SAT_MAX = 21'sd131071;
   localparam logic signed [20:0] C_SAT_MIN = -21'sd131072;

   logic signed [17:0] x0_q, x1_q, x2_q;
   logic signed [17:0] dv_q, edv_q, err_q;

   logic signed [18:0] s_w;
   logic signed [36:0] p_w;
   logic signed [19:0] isi_w;
   logic signed [20:0] sum_w;
   logic signed [20:0] diff_w;
   logic signed [17:0] dv_d;
   logic signed [17:0] err_d;

   function automatic logic signed [17:0] sat18(input logic signed [20:0] v);
      if (v > C_SAT_MAX)
         return 18'sh1FFFF;
      else if (v < C_SAT_MIN)
         return 18'sh20000;
      else
         return v[17:0];
   endfunction

   // Both neighbours carry the same gain; taking bits [36:17] is the floor shift.
   always_comb begin
      s_w    = {x0_q[17], x0_q} + {x2_q[17], x2_q};
      p_w    = 37'(s_w) * 37'(isi_power);
      isi_w  = p_w[36:17];
      sum_w  = {{3{x1_q[17]}}, x1_q} + {isi_w[19], isi_w};
      dv_d   = sat18(sum_w);
      diff_w = {{3{dv_d[17]}}, dv_d} - {{3{x1_q[17]}}, x1_q};
      err_d  = sat18(diff_w);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x0_q  <= '0;
         x1_q  <= '0;
         x2_q  <= '0;
         dv_q  <= '0;
         edv_q <= '0;
         err_q <= '0;
      end else if (clk_en) begin
         x0_q  <= in_data;
         x1_q  <= x0_q;
         x2_q  <= x1_q;
         dv_q  <= dv_d;
         edv_q <= x1_q;
         err_q <= err_d;
      end
   end

   assign decision_variable           = dv_q;
   assign errorless_decision_variable = edv_q;
   assign error                       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dut_for_mer_measurement.sv
// ============================================================================
// Module   : tb_dut_for_mer_measurement
// Purpose  : Scoreboard bench for the MER channel model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dut_for_mer_measurement;

   logic               clk = 1'b0;
   logic               reset;
   logic               clk_en;
   logic signed [17:0] in_data;
   logic signed [17:0] isi_power;
   logic signed [17:0] decision_variable;
   logic signed [17:0] errorless_decision_variable;
   logic signed [17:0] error;

   dut_for_mer_measurement u_dut (
      .clk                         (clk),
      .reset                       (reset),
      .clk_en                      (clk_en),
      .in_data                     (in_data),
      .isi_power                   (isi_power),
      .decision_variable           (decision_variable),
      .errorless_decision_variable (errorless_decision_variable),
      .error                       (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint dv;
      longint edv;
      longint err;
   } exp_t;

   int     checks = 0;
   int     errors = 0;
   longint m0 = 0, m1 = 0, m2 = 0;
   exp_t   sbq[$];
   exp_t   last = '{0, 0, 0};

   function automatic longint sat(input longint v);
      if (v > 131071)  return 131071;
      if (v < -131072) return -131072;
      return v;
   endfunction

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input exp_t e);
      chk({tag, "_dv"},  longint'(decision_variable), e.dv);
      chk({tag, "_edv"}, longint'(errorless_decision_variable), e.edv);
      chk({tag, "_err"}, longint'(error), e.err);
   endtask

   // Drive one enabled symbol, predict its output, then compare after the edge.
   task automatic sym(input longint d, input longint p, input string tag);
      exp_t   e;
      longint isi;
      @(negedge clk);
      in_data   = 18'(d);
      isi_power = 18'(p);
      clk_en    = 1'b1;
      isi   = ((m0 + m2) * p) >>> 17;
      e.dv  = sat(m1 + isi);
      e.edv = m1;
      e.err = sat(e.dv - m1);
      sbq.push_back(e);
      m2 = m1;
      m1 = m0;
      m0 = d;
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         errors++;
         $error("FAIL %s scoreboard empty observed 0 expected 1", tag);
      end else begin
         e = sbq.pop_front();
         last = e;
         chk_out(tag, e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         clk_en  = 1'b0;
         in_data = 18'($urandom_range(0, 262143));
         @(posedge clk);
         #1;
         chk_out("hold", last);
      end
   endtask

   longint syms[4] = '{-98304, -32768, 32768, 98304};

   initial begin
      reset     = 1'b0;
      clk_en    = 1'b0;
      in_data   = '0;
      isi_power = '0;
      #1;
      chk_out("reset", last);
      @(negedge clk);
      reset = 1'b1;

      // isi_power = 0: no impairment, plain 2-symbol delay
      for (int i = 0; i < 12; i++)
         sym(syms[$urandom_range(0, 3)], 0, "noisi");

      // Positive constant level with moderate ISI
      for (int i = 0; i < 5; i++)
         sym(32768, 9268, "posisi");
      chk("posisi_dv_abs",  longint'(decision_variable), 37402);
      chk("posisi_err_abs", longint'(error), 4634);

      for (int i = 0; i < 5; i++)
         sym(-32768, 9268, "negisi");
      chk("negisi_dv_abs",  longint'(decision_variable), -37402);
      chk("negisi_err_abs", longint'(error), -4634);

      // Saturation at both rails
      for (int i = 0; i < 5; i++)
         sym(131071, 131071, "satpos");
      chk("satpos_dv_abs", longint'(decision_variable), 131071);
      for (int i = 0; i < 5; i++)
         sym(-131072, 131071, "satneg");
      chk("satneg_dv_abs", longint'(decision_variable), -131072);

      // Clock enable low holds everything
      idle(10);

      // Random symbols, random signed gain, back-to-back enables
      for (int i = 0; i < 20; i++)
         sym(syms[$urandom_range(0, 3)], longint'($signed(18'($urandom_range(0, 262143)))), "rand");

      // Reset during an enabled cycle clears outputs without a clock edge
      @(negedge clk);
      clk_en = 1'b1;
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk_out("async_rst", '{0, 0, 0});
      @(posedge clk);
      #1;
      chk_out("rst_wins", '{0, 0, 0});
      m0 = 0; m1 = 0; m2 = 0;
      last = '{0, 0, 0};
      sbq.delete();
      @(negedge clk);
      reset  = 1'b1;
      clk_en = 1'b0;

      // Floor behaviour with unit gain and zero neighbours
      sym(1, 1, "floor_p");
      sym(0, 1, "floor_p");
      chk("floor_pos_err", longint'(error), 0);
      sym(0, 1, "floor_p");
      sym(-1, 1, "floor_n");
      sym(0, 1, "floor_n");
      chk("floor_neg_err", longint'(error), -1);
      sym(0, 1, "floor_n");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
